prco_regs_wb_arbiter: RTL and testbench
=======================================

# prco_regs_wb_arbiter

Write-port arbiter and busy-register scoreboard for the PRCO 8×16-bit register set. Two writeback requesters, the ALU and the load/store unit, share the register set's single write port. Requests are handshaked, arbitrated round-robin, and driven onto the register write port through one output register stage. The block also tracks which registers have an outstanding write and reports read-after-write hazards to the issue stage.

## Interface
Parameters:
- NREQ, 2: number of writeback requesters (0 = ALU, 1 = LSU); fixed at 2 for this revision
- CNT_W, 16: width of the conflict counter

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_alu_valid  in  1  ALU writeback request
- i_alu_seld  in  3  ALU destination register
- i_alu_datd  in  16  ALU write data
- q_alu_ready  out  1  ALU request accepted this cycle
- i_lsu_valid / i_lsu_seld / i_lsu_datd  in  1/3/16  LSU request, same meaning as the ALU fields
- q_lsu_ready  out  1  LSU request accepted this cycle
- q_we  out  1  to the register set write enable
- q_seld  out  3  to the register set destination select
- q_datd  out  16  to the register set write data
- i_rsv_valid  in  1  issue stage reserves a destination
- i_rsv_reg  in  3  register to reserve
- q_rsv_ready  out  1  reservation accepted
- i_chk_a, i_chk_b  in  3  issue-stage source registers
- q_hazard  out  1  either source register is busy
- q_busy  out  8  scoreboard, one bit per register
- q_conflicts  out  CNT_W  count of cycles in which both requesters were valid

## Operation
- Handshake: a request transfers when valid and ready are both 1. Valid, seld and datd are held stable until ready. Ready is combinational from the valid inputs and the arbiter pointer.
- Arbitration: with one requester valid, that requester is granted. With both valid, the requester named by the 1-bit pointer `rr` is granted and `rr` flips to the other requester. `rr` changes only on a contended grant. At most one grant per cycle.
- Output stage: on a grant, q_we<=1, q_seld<=seld, q_datd<=datd. With no grant, q_we<=0 and q_seld/q_datd hold their values.
- Scoreboard, set: busy[i_rsv_reg] sets when i_rsv_valid && q_rsv_ready.
- Scoreboard, clear: busy[q_seld] clears on the edge ending a cycle with q_we=1, which is the same edge at which the register set commits the write.
- Set and clear of the same register in the same cycle: the set wins and the bit stays 1.
- q_rsv_ready = !busy[i_rsv_reg] || (q_we && q_seld==i_rsv_reg).
- q_hazard = busy[i_chk_a] || busy[i_chk_b]. This is combinational and does not account for a clear in the current cycle; the issue stage stalls one extra cycle.
- Writes to non-busy registers are legal (initial SP/BP setup, for example). Clearing an already-clear bit is a no-op.
- q_conflicts increments on every cycle with both valids high and saturates at all-ones.

## Timing
- Reset (async assert, sync release) sets q_we=0, q_seld=0, q_datd=0, q_busy=0, rr=0 (ALU first), q_conflicts=0.
- While reset is asserted, q_alu_ready=q_lsu_ready=q_rsv_ready=0 and q_hazard=0.
- Latency: a request granted in cycle N gives q_we=1 in cycle N+1. The register set commits the write and busy clears at the edge ending N+1.
- A loser of a contended cycle is granted in the next cycle if it is still valid, so worst-case wait is 1 cycle.
- Back-to-back grants are permitted: q_we may stay high on consecutive cycles with different q_seld.
- Reset mid-operation: a pending q_we is dropped, all reservations are lost, and requesters must reissue.

## Structure
- Shared package/include `prco_constants`: REG_SP, REG_BP, the register-select width (3) and the data width (16). Add PRCO_WB_ALU=0 and PRCO_WB_LSU=1 there.
- One sub-module, `prco_rr_arb2`: the 2-way round-robin arbiter (valids in, grants out, pointer register). The scoreboard and output stage stay inline.

## Test plan
- Reset, then ALU valid seld=3 datd=0xBEEF -> q_alu_ready=1 in cycle 0; q_we=1, q_seld=3, q_datd=0xBEEF in cycle 1; q_we=0 in cycle 2.
- ALU (r1, 0x1111) and LSU (r2, 0x2222) valid together for 2 cycles -> ALU granted first, LSU second, q_conflicts=1. Repeat the test -> LSU is granted first.
- Reserve r5, then i_chk_a=5 -> q_hazard=1. Second reserve of r5 -> q_rsv_ready=0. LSU write to r5 -> busy[5] clears at the edge ending the q_we cycle, then q_hazard=0.
- In the cycle with q_we=1 and q_seld=5, reserve r5 -> q_rsv_ready=1 and busy[5] stays 1.
- Assert i_reset_n=0 while q_we=1 with busy=0x21 -> q_we=0, q_busy=0 immediately, without waiting for a clock edge.
- Hold both valids for 0x10000 cycles -> q_conflicts saturates at 0xFFFF.

Source files
------------

// File: rtl/prco_constants.sv
// Shared PRCO constants: register-select/data widths, special registers and writeback requester ids.
`default_nettype none

package prco_constants;

  localparam int RSEL_W = 3;
  localparam int DATA_W = 16;
  localparam int NREG   = 2 ** RSEL_W;

  localparam logic [RSEL_W-1:0] REG_SP = 3'd6;
  localparam logic [RSEL_W-1:0] REG_BP = 3'd7;

  localparam int PRCO_WB_ALU = 0;
  localparam int PRCO_WB_LSU = 1;

  typedef logic [RSEL_W-1:0] rsel_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

`default_nettype wire

// File: rtl/prco_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the winner of the next contended cycle.
`default_nettype none

module prco_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !rr))
      gnt[0] = 1'b1;
    else if (req[1])
      gnt[1] = 1'b1;
  end

  // Pointer only moves on contention, so an uncontested requester never loses priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr <= 1'b0;
    else if (&req)
      rr <= ~rr;
  end

endmodule

`default_nettype wire

// File: rtl/prco_regs_wb_arbiter.sv
// Register-set write-port arbiter (ALU/LSU) with one output stage and a busy-register scoreboard.
`default_nettype none

module prco_regs_wb_arbiter
  import prco_constants::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_alu_valid,
  input  logic [RSEL_W-1:0] i_alu_seld,
  input  logic [DATA_W-1:0] i_alu_datd,
  output logic              q_alu_ready,
  input  logic              i_lsu_valid,
  input  logic [RSEL_W-1:0] i_lsu_seld,
  input  logic [DATA_W-1:0] i_lsu_datd,
  output logic              q_lsu_ready,
  output logic              q_we,
  output logic [RSEL_W-1:0] q_seld,
  output logic [DATA_W-1:0] q_datd,
  input  logic              i_rsv_valid,
  input  logic [RSEL_W-1:0] i_rsv_reg,
  output logic              q_rsv_ready,
  input  logic [RSEL_W-1:0] i_chk_a,
  input  logic [RSEL_W-1:0] i_chk_b,
  output logic              q_hazard,
  output logic [NREG-1:0]   q_busy,
  output logic [CNT_W-1:0]  q_conflicts
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rsv_fire;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    req = '0;
    req[PRCO_WB_ALU] = i_alu_valid;
    req[PRCO_WB_LSU] = i_lsu_valid;
  end

  prco_rr_arb2 u_arb (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign q_alu_ready = i_reset_n && gnt[PRCO_WB_ALU];
  assign q_lsu_ready = i_reset_n && gnt[PRCO_WB_LSU];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_we   <= 1'b0;
      q_seld <= '0;
      q_datd <= '0;
    end else begin
      q_we <= |gnt;
      if (gnt[PRCO_WB_ALU]) begin
        q_seld <= i_alu_seld;
        q_datd <= i_alu_datd;
      end else if (gnt[PRCO_WB_LSU]) begin
        q_seld <= i_lsu_seld;
        q_datd <= i_lsu_datd;
      end
    end
  end

  // A register being committed this cycle may be re-reserved immediately.
  assign q_rsv_ready = i_reset_n &&
                       (!q_busy[i_rsv_reg] || (q_we && (q_seld == i_rsv_reg)));
  assign rsv_fire    = i_rsv_valid && q_rsv_ready;

  // Clear first, then set, so a same-cycle set wins.
  always_comb begin
    busy_nxt = q_busy;
    if (q_we)
      busy_nxt[q_seld] = 1'b0;
    if (rsv_fire)
      busy_nxt[i_rsv_reg] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      q_busy <= '0;
    else
      q_busy <= busy_nxt;
  end

  assign q_hazard = i_reset_n && (q_busy[i_chk_a] || q_busy[i_chk_b]);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      q_conflicts <= '0;
    else if ((&req) && !(&q_conflicts))
      q_conflicts <= q_conflicts + 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_prco_regs_wb_arbiter.sv
// Directed self-checking bench for prco_regs_wb_arbiter.
`default_nettype none

module tb_prco_regs_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, rsv_valid;
  logic [2:0]  alu_seld, lsu_seld, rsv_reg, chk_a, chk_b;
  logic [15:0] alu_datd, lsu_datd;
  logic        alu_ready, lsu_ready, we, rsv_ready, hazard;
  logic [2:0]  seld;
  logic [15:0] datd;
  logic [7:0]  busy;
  logic [15:0] conflicts;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  prco_regs_wb_arbiter #(.NREQ(2), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_alu_valid (alu_valid),
    .i_alu_seld  (alu_seld),
    .i_alu_datd  (alu_datd),
    .q_alu_ready (alu_ready),
    .i_lsu_valid (lsu_valid),
    .i_lsu_seld  (lsu_seld),
    .i_lsu_datd  (lsu_datd),
    .q_lsu_ready (lsu_ready),
    .q_we        (we),
    .q_seld      (seld),
    .q_datd      (datd),
    .i_rsv_valid (rsv_valid),
    .i_rsv_reg   (rsv_reg),
    .q_rsv_ready (rsv_ready),
    .i_chk_a     (chk_a),
    .i_chk_b     (chk_b),
    .q_hazard    (hazard),
    .q_busy      (busy),
    .q_conflicts (conflicts)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_seld = 3'd0; alu_datd = 16'h0;
    lsu_valid = 1'b1; lsu_seld = 3'd0; lsu_datd = 16'h0;
    rsv_valid = 1'b1; rsv_reg = 3'd0; chk_a = 3'd0; chk_b = 3'd0;
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_rsv_ready", rsv_ready, 0);
    check("rst_hazard", hazard, 0);
    step(); step();
    check("rst_we", we, 0);
    check("rst_seld_datd", {seld, datd}, 0);
    check("rst_busy", busy, 0);
    check("rst_conflicts", conflicts, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0; rsv_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // single ALU write
    alu_valid = 1'b1; alu_seld = 3'd3; alu_datd = 16'hBEEF;
    #1;
    check("alu_ready_c0", {alu_ready, lsu_ready}, 2'b10);
    step();
    alu_valid = 1'b0;
    check("alu_we_c1", {we, seld, datd}, {1'b1, 3'd3, 16'hBEEF});
    step();
    check("alu_we_c2", {we, seld, datd}, {1'b0, 3'd3, 16'hBEEF});

    // contention, pointer starts at ALU
    alu_valid = 1'b1; alu_seld = 3'd1; alu_datd = 16'h1111;
    lsu_valid = 1'b1; lsu_seld = 3'd2; lsu_datd = 16'h2222;
    #1;
    check("cont1_ready", {alu_ready, lsu_ready}, 2'b10);
    step();
    alu_valid = 1'b0;
    check("cont1_first", {we, seld, datd}, {1'b1, 3'd1, 16'h1111});
    check("cont1_lsu_ready", {alu_ready, lsu_ready}, 2'b01);
    step();
    lsu_valid = 1'b0;
    check("cont1_second", {we, seld, datd}, {1'b1, 3'd2, 16'h2222});
    check("cont1_conflicts", conflicts, 1);

    // contention again, pointer now at LSU
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    check("cont2_ready", {alu_ready, lsu_ready}, 2'b01);
    step();
    lsu_valid = 1'b0;
    check("cont2_first", {we, seld, datd}, {1'b1, 3'd2, 16'h2222});
    check("cont2_alu_ready", {alu_ready, lsu_ready}, 2'b10);
    step();
    alu_valid = 1'b0;
    check("cont2_second", {we, seld, datd}, {1'b1, 3'd1, 16'h1111});
    check("cont2_conflicts", conflicts, 2);
    step();
    check("cont2_idle", we, 0);

    // scoreboard
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    #1;
    check("rsv5_ready", rsv_ready, 1);
    step();
    rsv_valid = 1'b0;
    check("rsv5_busy", busy, 8'h20);
    chk_a = 3'd5; chk_b = 3'd0;
    #1;
    check("hazard_a", hazard, 1);
    chk_a = 3'd0; chk_b = 3'd4;
    #1;
    check("no_hazard", hazard, 0);
    chk_b = 3'd5;
    #1;
    check("hazard_b", hazard, 1);
    chk_a = 3'd5; chk_b = 3'd0;
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    #1;
    check("rsv5_again_blocked", rsv_ready, 0);
    rsv_valid = 1'b0;
    lsu_valid = 1'b1; lsu_seld = 3'd5; lsu_datd = 16'h5555;
    #1;
    check("lsu_w5_ready", lsu_ready, 1);
    step();
    lsu_valid = 1'b0;
    check("lsu_w5_we", {we, seld, datd}, {1'b1, 3'd5, 16'h5555});
    check("busy_before_commit", busy, 8'h20);
    check("hazard_during_we", hazard, 1);
    step();
    check("busy_after_commit", busy, 8'h00);
    check("hazard_cleared", hazard, 0);

    // re-reserve during the committing cycle
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    step();
    rsv_valid = 1'b0;
    lsu_valid = 1'b1; lsu_datd = 16'h6666;
    step();
    lsu_valid = 1'b0;
    check("set_clr_we", {we, seld}, {1'b1, 3'd5});
    rsv_valid = 1'b1; rsv_reg = 3'd5;
    #1;
    check("set_clr_rsv_ready", rsv_ready, 1);
    step();
    rsv_valid = 1'b0;
    check("set_wins", busy, 8'h20);

    // async reset while a write is pending
    rsv_valid = 1'b1; rsv_reg = 3'd0;
    step();
    rsv_valid = 1'b0;
    alu_valid = 1'b1; alu_seld = 3'd3; alu_datd = 16'h7777;
    step();
    alu_valid = 1'b0;
    check("pre_reset_state", {we, busy}, {1'b1, 8'h21});
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", we, 0);
    check("async_rst_busy", busy, 8'h00);
    check("async_rst_out", {seld, datd}, 0);
    check("async_rst_conflicts", conflicts, 0);
    step();
    rst_n = 1'b1;
    step();

    // saturation of the conflict counter
    alu_valid = 1'b1; lsu_valid = 1'b1;
    for (int i = 0; i < 16'hFFFF; i++) step();
    check("conflicts_at_max", conflicts, 16'hFFFF);
    step();
    check("conflicts_saturated", conflicts, 16'hFFFF);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
